// File: rtl/bin_a_bcd.sv
// 14-bit binary to 4-digit BCD converter using serial double-dabble (one iteration per clock).
// Results are published only on completion; over-range values either saturate or wrap.
module bin_a_bcd #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [13:0] i_Bin,
  output logic [3:0]  o_Datos1,
  output logic [3:0]  o_Datos2,
  output logic [3:0]  o_Datos3,
  output logic [3:0]  o_Datos4,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_ovf_q, pend_ovf_d;
  logic [15:0] dig_q, dig_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [15:0] adj;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_ovf_q <= 1'b0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      pend_ovf_q <= pend_ovf_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_ovf_d = pend_ovf_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    adj        = bcd_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          bin_d      = i_Bin;
          bcd_d      = '0;
          cnt_d      = '0;
          // Over-range is decided from the captured value; the 16-bit scratch drops the fifth digit.
          pend_ovf_d = (i_Bin > 14'd9999);
          state_d    = ST_CONV;
        end
      end

      ST_CONV: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        dig_d   = (SAT_EN && pend_ovf_q) ? 16'h9999 : bcd_q;
        ovf_d   = pend_ovf_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Datos1 = dig_q[15:12];
  assign o_Datos2 = dig_q[11:8];
  assign o_Datos3 = dig_q[7:4];
  assign o_Datos4 = dig_q[3:0];
  assign o_Busy   = (state_q != ST_IDLE);
  assign o_Done   = done_q;
  assign o_Ovf    = ovf_q;

endmodule

// File: tb/tb_bin_a_bcd.sv
// Bench for bin_a_bcd: saturating and wrapping instances driven together, checked against
// a decimal-arithmetic reference model.
module tb_bin_a_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;

  logic [3:0] s1, s2, s3, s4, w1, w2, w3, w4;
  logic       s_busy, s_done, s_ovf, w_busy, w_done, w_ovf;
  logic [15:0] s_dig, w_dig;

  assign s_dig = {s1, s2, s3, s4};
  assign w_dig = {w1, w2, w3, w4};

  always #5 clk = ~clk;

  bin_a_bcd #(.SAT_EN(1'b1)) dut_sat (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Bin(bin),
    .o_Datos1(s1), .o_Datos2(s2), .o_Datos3(s3), .o_Datos4(s4),
    .o_Busy(s_busy), .o_Done(s_done), .o_Ovf(s_ovf)
  );

  bin_a_bcd #(.SAT_EN(1'b0)) dut_wrap (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Bin(bin),
    .o_Datos1(w1), .o_Datos2(w2), .o_Datos3(w3), .o_Datos4(w4),
    .o_Busy(w_busy), .o_Done(w_done), .o_Ovf(w_ovf)
  );

  int n_chk = 0;
  int n_err = 0;
  int s_pulses = 0;
  int w_pulses = 0;
  int exp_pulses = 0;

  logic [15:0] s_prev = '0;
  logic [15:0] w_prev = '0;
  logic        s_pov = 1'b0;
  logic        w_pov = 1'b0;

  always @(negedge clk) begin
    if (s_done) s_pulses++;
    if (w_done) w_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the requested value.
  function automatic logic [15:0] ref_bcd(input int v, input bit sat);
    int x;
    x = v;
    if (x > 9999) x = sat ? 9999 : (x % 10000);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic run_conv(input int v);
    logic [15:0] es, ew;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk); #1;
    chk("busy_edge0", {s_busy, w_busy}, 2'b11);
    chk("done_clear", {s_done, w_done}, 2'b00);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 8);
      bin   = 14'($urandom);
      @(posedge clk); #1;
      chk("busy_conv", {s_busy, w_busy}, 2'b11);
      chk("done_conv", {s_done, w_done}, 2'b00);
      chk("hold_sat", {s_ovf, s_dig}, {s_pov, s_prev});
      chk("hold_wrap", {w_ovf, w_dig}, {w_pov, w_prev});
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    es = ref_bcd(v, 1'b1);
    ew = ref_bcd(v, 1'b0);
    chk("done_pulse", {s_done, w_done}, 2'b11);
    chk("busy_end", {s_busy, w_busy}, 2'b00);
    chk("digits_sat", s_dig, es);
    chk("digits_wrap", w_dig, ew);
    chk("ovf", {s_ovf, w_ovf}, {2{v > 9999}});
    exp_pulses++;
    s_prev = es;
    w_prev = ew;
    s_pov  = (v > 9999);
    w_pov  = (v > 9999);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", {s_done, w_done}, 2'b00);
      chk("idle_busy", {s_busy, w_busy}, 2'b00);
      chk("idle_hold", {s_ovf, s_dig, w_ovf, w_dig}, {s_pov, s_prev, w_pov, w_prev});
    end
  endtask

  task automatic abort_conv(input int v, input int k_abort);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk);
    for (int k = 1; k < k_abort; k++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk("abort_async_sat", {s_busy, s_done, s_ovf, s_dig}, '0);
    chk("abort_async_wrap", {w_busy, w_done, w_ovf, w_dig}, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold", {s_busy, s_done, s_ovf, s_dig, w_busy, w_done, w_ovf, w_dig}, '0);
    @(negedge clk);
    rst    = 1'b0;
    s_prev = '0;
    w_prev = '0;
    s_pov  = 1'b0;
    w_pov  = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_sat", {s_busy, s_done, s_ovf, s_dig}, '0);
    chk("reset_wrap", {w_busy, w_done, w_ovf, w_dig}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    run_conv(1234);
    idle(1);
    run_conv(0);
    run_conv(9999);
    run_conv(10);
    idle(1);
    run_conv(12345);
    run_conv(16383);
    run_conv(10000);
    idle(2);
    run_conv(42);
    run_conv(5678);
    abort_conv(321, 7);
    idle(1);
    run_conv(321);
    idle(1);
    run_conv(7);
    run_conv(8000);
    idle(1);

    for (int r = 0; r < 24; r++) begin
      int v;
      if (($urandom % 4) == 0) v = int'($urandom_range(10000, 16383));
      else                     v = int'($urandom_range(0, 9999));
      run_conv(v);
      if (($urandom % 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk("pulses_sat", s_pulses, exp_pulses);
    chk("pulses_wrap", w_pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
